// File: rtl/sram_bus_arbiter_if.sv
// Bundle of the fetch, data and memory-side handshakes around the SRAM arbiter.
// slave is the arbiter's view, master is the view of the surrounding environment.
interface sram_bus_arbiter_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
);
  logic                    inst_req;
  logic [ADDR_WIDTH-1:0]   inst_addr;
  logic                    inst_addr_ok;
  logic                    inst_data_ok;
  logic [DATA_WIDTH-1:0]   inst_rdata;

  logic                    data_req;
  logic                    data_wr;
  logic [1:0]              data_size;
  logic [DATA_WIDTH/8-1:0] data_wstrb;
  logic [ADDR_WIDTH-1:0]   data_addr;
  logic [DATA_WIDTH-1:0]   data_wdata;
  logic                    data_addr_ok;
  logic                    data_data_ok;
  logic [DATA_WIDTH-1:0]   data_rdata;

  logic                    mem_req;
  logic                    mem_wr;
  logic [1:0]              mem_size;
  logic [DATA_WIDTH/8-1:0] mem_wstrb;
  logic [ADDR_WIDTH-1:0]   mem_addr;
  logic [DATA_WIDTH-1:0]   mem_wdata;
  logic                    mem_addr_ok;
  logic                    mem_data_ok;
  logic [DATA_WIDTH-1:0]   mem_rdata;

  modport slave (
    input  inst_req, inst_addr,
    output inst_addr_ok, inst_data_ok, inst_rdata,
    input  data_req, data_wr, data_size, data_wstrb, data_addr, data_wdata,
    output data_addr_ok, data_data_ok, data_rdata,
    output mem_req, mem_wr, mem_size, mem_wstrb, mem_addr, mem_wdata,
    input  mem_addr_ok, mem_data_ok, mem_rdata
  );

  modport master (
    output inst_req, inst_addr,
    input  inst_addr_ok, inst_data_ok, inst_rdata,
    output data_req, data_wr, data_size, data_wstrb, data_addr, data_wdata,
    input  data_addr_ok, data_data_ok, data_rdata,
    input  mem_req, mem_wr, mem_size, mem_wstrb, mem_addr, mem_wdata,
    output mem_addr_ok, mem_data_ok, mem_rdata
  );
endinterface

// File: rtl/sram_bus_arbiter.sv
// Shares one SRAM-like port between instruction fetch and data access.
// Data wins arbitration except when fetch has been starved for STARVE_LIMIT
// grants. In-order responses are steered back by an owner FIFO; fetch
// responses issued before a flush are dropped.
//
// Lock FSM states:
//   state     | meaning
//   ST_OPEN   | no stalled request; arbitrate every cycle
//   ST_LOCKED | a request was presented without mem_addr_ok; replay latched
//             | owner/payload until memory accepts it
module sram_bus_arbiter #(
  parameter int ADDR_WIDTH      = 32,
  parameter int DATA_WIDTH      = 32,
  parameter int MAX_OUTSTANDING = 2,
  parameter int STARVE_LIMIT    = 4
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             flush,
  output logic             protocol_err,
  sram_bus_arbiter_if.slave bus
);
  localparam int STRB_W = DATA_WIDTH / 8;
  localparam int PTR_W  = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
  localparam int CNT_W  = $clog2(MAX_OUTSTANDING + 1);
  localparam int STV_W  = $clog2(STARVE_LIMIT + 1);

  typedef struct packed {
    logic                  wr;
    logic [1:0]            size;
    logic [STRB_W-1:0]     wstrb;
    logic [ADDR_WIDTH-1:0] addr;
    logic [DATA_WIDTH-1:0] wdata;
  } req_t;

  typedef enum logic {ST_OPEN = 1'b0, ST_LOCKED = 1'b1} lock_state_t;
  typedef enum logic {OWN_DATA = 1'b0, OWN_INST = 1'b1} owner_t;

  lock_state_t                lock_state;
  owner_t                     lat_owner;
  req_t                       lat_req;
  logic                       lat_flushed;

  logic [MAX_OUTSTANDING-1:0] fifo_inst;
  logic [MAX_OUTSTANDING-1:0] fifo_discard;
  logic [PTR_W-1:0]           wr_ptr;
  logic [PTR_W-1:0]           rd_ptr;
  logic [CNT_W-1:0]           count;
  logic [STV_W-1:0]           starve_cnt;

  req_t inst_pay;
  req_t data_pay;
  req_t cur_req;
  logic mem_req_c;
  logic grant_inst;
  logic issue_ok;
  logic force_inst;
  logic accept;
  logic push_discard;
  logic pop;
  logic head_inst;
  logic head_discard;

  function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
    next_ptr = (p == PTR_W'(MAX_OUTSTANDING - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  // fetches are always word reads with no store payload
  assign inst_pay   = {1'b0, 2'd2, {STRB_W{1'b0}}, bus.inst_addr, {DATA_WIDTH{1'b0}}};
  assign data_pay   = {bus.data_wr, bus.data_size, bus.data_wstrb, bus.data_addr, bus.data_wdata};
  // a pop in the same cycle does not free a slot: use the registered count
  assign issue_ok   = (count < CNT_W'(MAX_OUTSTANDING));
  assign force_inst = bus.inst_req && (starve_cnt == STV_W'(STARVE_LIMIT));

  // pick the owner and payload presented to memory this cycle
  always_comb begin
    mem_req_c  = 1'b0;
    grant_inst = 1'b0;
    cur_req    = '0;
    if (lock_state == ST_LOCKED) begin
      mem_req_c  = 1'b1;
      grant_inst = (lat_owner == OWN_INST);
      cur_req    = lat_req;
    end else if (issue_ok) begin
      if (bus.data_req && !force_inst) begin
        mem_req_c = 1'b1;
        cur_req   = data_pay;
      end else if (bus.inst_req) begin
        mem_req_c  = 1'b1;
        grant_inst = 1'b1;
        cur_req    = inst_pay;
      end
    end
  end

  assign accept       = mem_req_c && bus.mem_addr_ok;
  // a fetch flushed while stalled is still issued but its answer is dropped
  assign push_discard = grant_inst && (flush || ((lock_state == ST_LOCKED) && lat_flushed));
  assign pop          = bus.mem_data_ok && (count != '0);
  assign head_inst    = fifo_inst[rd_ptr];
  assign head_discard = fifo_discard[rd_ptr];

  assign bus.mem_req      = mem_req_c;
  assign bus.mem_wr       = cur_req.wr;
  assign bus.mem_size     = cur_req.size;
  assign bus.mem_wstrb    = cur_req.wstrb;
  assign bus.mem_addr     = cur_req.addr;
  assign bus.mem_wdata    = cur_req.wdata;
  assign bus.inst_addr_ok = accept && grant_inst;
  assign bus.data_addr_ok = accept && !grant_inst;
  assign bus.inst_data_ok = pop && head_inst && !head_discard;
  assign bus.data_data_ok = pop && !head_inst;
  assign bus.inst_rdata   = bus.mem_rdata;
  assign bus.data_rdata   = bus.mem_rdata;

  // lock FSM: hold owner and payload steady while memory stalls
  always_ff @(posedge clock) begin
    if (reset) begin
      lock_state  <= ST_OPEN;
      lat_owner   <= OWN_DATA;
      lat_req     <= '0;
      lat_flushed <= 1'b0;
    end else begin
      case (lock_state)
        ST_OPEN: begin
          if (mem_req_c && !bus.mem_addr_ok) begin
            lock_state  <= ST_LOCKED;
            lat_owner   <= grant_inst ? OWN_INST : OWN_DATA;
            lat_req     <= cur_req;
            lat_flushed <= flush;
          end
        end
        ST_LOCKED: begin
          if (bus.mem_addr_ok) lock_state <= ST_OPEN;
          else                 lat_flushed <= lat_flushed | flush;
        end
        default: lock_state <= ST_OPEN;
      endcase
    end
  end

  // outstanding-owner FIFO; flush marks every queued fetch as discard
  always_ff @(posedge clock) begin
    if (reset) begin
      fifo_inst    <= '0;
      fifo_discard <= '0;
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      count        <= '0;
    end else begin
      for (int i = 0; i < MAX_OUTSTANDING; i++) begin
        if (flush && fifo_inst[i]) fifo_discard[i] <= 1'b1;
      end
      if (accept) begin
        fifo_inst[wr_ptr]    <= grant_inst;
        fifo_discard[wr_ptr] <= push_discard;
        wr_ptr               <= next_ptr(wr_ptr);
      end
      if (pop) rd_ptr <= next_ptr(rd_ptr);
      case ({accept, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  // count data grants that pass over a waiting fetch
  always_ff @(posedge clock) begin
    if (reset) begin
      starve_cnt <= '0;
    end else if (!bus.inst_req || (accept && grant_inst)) begin
      starve_cnt <= '0;
    end else if (accept && (starve_cnt != STV_W'(STARVE_LIMIT))) begin
      starve_cnt <= starve_cnt + STV_W'(1);
    end
  end

  // sticky flag for a response nobody asked for
  always_ff @(posedge clock) begin
    if (reset) begin
      protocol_err <= 1'b0;
    end else if (bus.mem_data_ok && (count == '0)) begin
      protocol_err <= 1'b1;
    end
  end
endmodule

// File: tb/tb_sram_bus_arbiter.sv
// Directed scenarios followed by a randomized run, all checked every cycle
// against a queue-based model of the arbiter.
module tb_sram_bus_arbiter;
  localparam int AW   = 32;
  localparam int DW   = 32;
  localparam int MAXO = 2;
  localparam int SL   = 4;

  logic clock = 1'b0;
  logic reset;
  logic flush;
  logic protocol_err;

  sram_bus_arbiter_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

  sram_bus_arbiter #(
    .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .MAX_OUTSTANDING(MAXO), .STARVE_LIMIT(SL)
  ) dut (
    .clock(clock), .reset(reset), .flush(flush), .protocol_err(protocol_err), .bus(bus)
  );

  always #5 clock = ~clock;

  int total = 0;
  int bad   = 0;

  // model state: outstanding queue, stalled request, starvation count, error flag
  typedef struct { bit is_inst; bit discard; } ent_t;
  ent_t mq[$];
  bit          h_valid, h_inst, h_flushed;
  logic [70:0] h_pay;
  int          starve;
  bit          m_perr;

  // per-cycle predictions
  bit          g_req, g_inst;
  logic [70:0] g_pay;
  bit          e_acc, e_iaok, e_daok, e_idok, e_ddok;
  bit          last_iaok, last_daok;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_clear();
    mq.delete();
    h_valid = 0; h_inst = 0; h_flushed = 0; h_pay = '0;
    starve = 0; m_perr = 0;
  endtask

  task automatic model_predict();
    g_req = 0; g_inst = 0; g_pay = '0;
    if (h_valid) begin
      g_req = 1; g_inst = h_inst; g_pay = h_pay;
    end else if (mq.size() < MAXO && (bus.data_req || bus.inst_req)) begin
      g_req  = 1;
      g_inst = !bus.data_req || (bus.inst_req && starve == SL);
      g_pay  = g_inst ? {1'b0, 2'd2, 4'h0, bus.inst_addr, 32'h0}
                      : {bus.data_wr, bus.data_size, bus.data_wstrb, bus.data_addr, bus.data_wdata};
    end
    e_acc  = g_req && bus.mem_addr_ok;
    e_iaok = e_acc && g_inst;
    e_daok = e_acc && !g_inst;
    e_idok = 0; e_ddok = 0;
    if (bus.mem_data_ok && mq.size() > 0) begin
      e_idok = mq[0].is_inst && !mq[0].discard;
      e_ddok = !mq[0].is_inst;
    end
  endtask

  task automatic model_update();
    ent_t e;
    if (reset) begin
      model_clear();
      return;
    end
    if (bus.mem_data_ok) begin
      if (mq.size() == 0) m_perr = 1;
      else void'(mq.pop_front());
    end
    if (flush) foreach (mq[i]) if (mq[i].is_inst) mq[i].discard = 1;
    if (e_acc) begin
      e.is_inst = g_inst;
      e.discard = g_inst && (flush || (h_valid && h_flushed));
      mq.push_back(e);
    end
    if (!bus.inst_req || (e_acc && g_inst)) starve = 0;
    else if (e_acc) starve = (starve + 1 > SL) ? SL : starve + 1;
    if (e_acc) h_valid = 0;
    else if (h_valid) h_flushed = h_flushed | flush;
    else if (g_req) begin
      h_valid = 1; h_inst = g_inst; h_pay = g_pay; h_flushed = flush;
    end
  endtask

  task automatic sample();
    @(negedge clock);
    model_predict();
    chk("mem_req", bus.mem_req, g_req);
    chk("mem_payload", {bus.mem_wr, bus.mem_size, bus.mem_wstrb, bus.mem_addr, bus.mem_wdata}, g_pay);
    chk("inst_addr_ok", bus.inst_addr_ok, e_iaok);
    chk("data_addr_ok", bus.data_addr_ok, e_daok);
    chk("inst_data_ok", bus.inst_data_ok, e_idok);
    chk("data_data_ok", bus.data_data_ok, e_ddok);
    chk("inst_rdata", bus.inst_rdata, bus.mem_rdata);
    chk("data_rdata", bus.data_rdata, bus.mem_rdata);
    chk("protocol_err", protocol_err, m_perr);
    last_iaok = e_iaok;
    last_daok = e_daok;
  endtask

  task automatic advance();
    @(posedge clock);
    model_update();
    #1;
  endtask

  task automatic set_data(input bit wr, input logic [31:0] addr, input logic [31:0] wdata);
    bus.data_req = 1; bus.data_wr = wr; bus.data_size = 2'd2;
    bus.data_wstrb = wr ? 4'hF : 4'h0; bus.data_addr = addr; bus.data_wdata = wdata;
  endtask

  task automatic drain();
    bus.inst_req = 0; bus.data_req = 0; flush = 0; bus.mem_addr_ok = 0;
    for (int k = 0; k < 8 && mq.size() > 0; k++) begin
      bus.mem_data_ok = 1; bus.mem_rdata = $urandom;
      sample(); advance();
    end
    bus.mem_data_ok = 0;
  endtask

  task automatic pulse_reset();
    reset = 1; sample(); advance(); reset = 0;
  endtask

  initial begin
    logic [9:0] pat;
    reset = 1; flush = 0;
    bus.inst_req = 0; bus.inst_addr = '0;
    bus.data_req = 0; bus.data_wr = 0; bus.data_size = '0; bus.data_wstrb = '0;
    bus.data_addr = '0; bus.data_wdata = '0;
    bus.mem_addr_ok = 0; bus.mem_data_ok = 0; bus.mem_rdata = '0;
    last_iaok = 0; last_daok = 0;
    model_clear();
    repeat (3) @(posedge clock);
    #1;
    reset = 0;

    // reset state
    sample();
    chk("reset_mem_req", bus.mem_req, 1'b0);
    chk("reset_perr", protocol_err, 1'b0);
    advance();

    // 1: simultaneous requests, data first then fetch
    set_data(0, 32'h200, 0);
    bus.inst_req = 1; bus.inst_addr = 32'h100; bus.mem_addr_ok = 1;
    sample();
    chk("t1_data_first", bus.data_addr_ok, 1'b1);
    chk("t1_inst_wait", bus.inst_addr_ok, 1'b0);
    advance();
    bus.data_req = 0;
    sample();
    chk("t1_inst_next", bus.inst_addr_ok, 1'b1);
    advance();
    bus.inst_req = 0;
    drain();

    // 2: starvation guard forces every fifth grant to fetch
    pat = 10'b10_0001_0000;
    bus.inst_req = 1; bus.inst_addr = 32'h1100;
    set_data(0, 32'h2100, 0);
    bus.mem_addr_ok = 1;
    for (int k = 0; k < 10; k++) begin
      bus.mem_data_ok = (mq.size() > 0);
      bus.mem_rdata = $urandom;
      sample();
      chk("t2_inst_grant", bus.inst_addr_ok, pat[k]);
      chk("t2_data_grant", bus.data_addr_ok, !pat[k]);
      advance();
      if (last_iaok) bus.inst_addr = bus.inst_addr + 4;
      if (last_daok) bus.data_addr = bus.data_addr + 4;
    end
    drain();

    // 3: stalled fetch keeps its payload even when data arrives
    bus.inst_req = 1; bus.inst_addr = 32'h1000; bus.mem_addr_ok = 0;
    for (int k = 0; k < 3; k++) begin
      sample();
      chk("t3_addr", bus.mem_addr, 32'h1000);
      chk("t3_wr", bus.mem_wr, 1'b0);
      chk("t3_req", bus.mem_req, 1'b1);
      advance();
      set_data(1, 32'h2000, 32'hCAFE_0001);
    end
    bus.mem_addr_ok = 1;
    sample();
    chk("t3_inst_acc", bus.inst_addr_ok, 1'b1);
    chk("t3_addr_acc", bus.mem_addr, 32'h1000);
    advance();
    bus.inst_req = 0;
    sample();
    chk("t3_data_acc", bus.data_addr_ok, 1'b1);
    chk("t3_data_addr", bus.mem_addr, 32'h2000);
    advance();
    drain();

    // 4: full FIFO blocks issue; a pop frees the slot one cycle later
    set_data(0, 32'h300, 0); bus.mem_addr_ok = 1;
    sample(); advance();
    bus.data_addr = 32'h304;
    sample(); advance();
    bus.data_addr = 32'h308;
    for (int k = 0; k < 2; k++) begin
      sample(); chk("t4_full_req", bus.mem_req, 1'b0); advance();
    end
    bus.mem_data_ok = 1; bus.mem_rdata = 32'h4444;
    sample();
    chk("t4_pop_no_issue", bus.mem_req, 1'b0);
    chk("t4_pop_data_ok", bus.data_data_ok, 1'b1);
    advance();
    bus.mem_data_ok = 0;
    sample();
    chk("t4_issue_after", bus.data_addr_ok, 1'b1);
    chk("t4_addr", bus.mem_addr, 32'h308);
    advance();
    drain();

    // 5: flushed fetch response is swallowed, the next one is delivered
    bus.inst_req = 1; bus.inst_addr = 32'h400; bus.mem_addr_ok = 1;
    sample(); advance();
    bus.inst_req = 0; flush = 1;
    sample(); advance();
    flush = 0; bus.mem_data_ok = 1; bus.mem_rdata = 32'hDEADBEEF;
    sample();
    chk("t5_discard", bus.inst_data_ok, 1'b0);
    advance();
    bus.mem_data_ok = 0; bus.inst_req = 1; bus.inst_addr = 32'h404;
    sample(); advance();
    bus.inst_req = 0; bus.mem_data_ok = 1; bus.mem_rdata = 32'h1234_5678;
    sample();
    chk("t5_deliver", bus.inst_data_ok, 1'b1);
    chk("t5_rdata", bus.inst_rdata, 32'h1234_5678);
    advance();
    bus.mem_data_ok = 0;

    // 6: interleaved routing, then a stray response
    set_data(0, 32'h500, 0); bus.mem_addr_ok = 1;
    sample(); chk("t6_load_acc", bus.data_addr_ok, 1'b1); advance();
    bus.data_req = 0; bus.inst_req = 1; bus.inst_addr = 32'h600;
    sample(); chk("t6_inst_acc", bus.inst_addr_ok, 1'b1); advance();
    bus.inst_req = 0; set_data(1, 32'h700, 32'h77); bus.mem_data_ok = 1; bus.mem_rdata = 32'h11;
    sample();
    chk("t6_full", bus.mem_req, 1'b0);
    chk("t6_rsp1", bus.data_data_ok, 1'b1);
    chk("t6_rsp1_data", bus.data_rdata, 32'h11);
    advance();
    bus.mem_rdata = 32'h22;
    sample();
    chk("t6_rsp2", bus.inst_data_ok, 1'b1);
    chk("t6_store_acc", bus.data_addr_ok, 1'b1);
    advance();
    bus.data_req = 0; bus.mem_rdata = 32'h33;
    sample(); chk("t6_rsp3", bus.data_data_ok, 1'b1); advance();
    sample(); chk("t6_stray_before", protocol_err, 1'b0); advance();
    bus.mem_data_ok = 0;
    sample(); chk("t6_perr", protocol_err, 1'b1); advance();

    // 7: reset mid-transaction, then a late response
    pulse_reset();
    bus.inst_req = 1; bus.inst_addr = 32'h800; bus.mem_addr_ok = 1;
    sample(); advance();
    bus.inst_req = 0;
    pulse_reset();
    bus.mem_data_ok = 1;
    sample(); chk("t7_late_no_ok", bus.inst_data_ok, 1'b0); advance();
    bus.mem_data_ok = 0;
    sample(); chk("t7_perr", protocol_err, 1'b1); advance();
    pulse_reset();

    // randomized traffic
    for (int c = 0; c < 800; c++) begin
      if (!bus.inst_req || last_iaok) begin
        bus.inst_req  = ($urandom_range(0, 2) != 0);
        bus.inst_addr = $urandom & 32'hFFFF_FFFC;
      end
      if (!bus.data_req || last_daok) begin
        bus.data_req   = ($urandom_range(0, 2) != 0);
        bus.data_wr    = 1'($urandom_range(0, 1));
        bus.data_size  = 2'($urandom_range(0, 2));
        bus.data_wstrb = 4'($urandom);
        bus.data_addr  = $urandom;
        bus.data_wdata = $urandom;
      end
      bus.mem_addr_ok = ($urandom_range(0, 2) != 0);
      bus.mem_data_ok = (mq.size() > 0) && ($urandom_range(0, 1) == 1);
      bus.mem_rdata   = $urandom;
      flush = ($urandom_range(0, 11) == 0);
      reset = ($urandom_range(0, 199) == 0);
      sample();
      advance();
    end
    reset = 0;
    bus.mem_addr_ok = 1;
    for (int k = 0; k < 4 && h_valid; k++) begin
      sample(); advance();
    end
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
